gas_alarm_controller: RTL and testbench

Sequences the household response to the serial gas detector's decoded gas code. Debounces detections, then latches an alarm and drives the gas shut-off valve, ventilation fan and alarm sounder. Holds the alarm until the user acknowledges with the air clear, then runs a timed ventilation purge. Sits between the gas detector output and the actuator/annunciator outputs of the smart-house module.

---
 rtl/gas_alarm_controller.sv | 139 +++++++++++++
 tb/tb_gas_alarm_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gas_alarm_controller.sv
// gas_alarm_controller: debounces the decoded gas code, latches an alarm event,
// drives the valve/fan/sounder and runs a timed ventilation purge after acknowledge.
module gas_alarm_controller #(
   parameter int unsigned CONFIRM_CYCLES = 4,
   parameter int unsigned VENT_CYCLES    = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [2:0]       gas_code,
   input  logic             ack,
   output logic             alarm,
   output logic             fan_on,
   output logic             valve_close,
   output logic [2:0]       latched_gas,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] event_count
);

   localparam int unsigned CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
   localparam int unsigned VENT_W = (VENT_CYCLES > 1) ? $clog2(VENT_CYCLES) : 1;
   localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);
   localparam logic [VENT_W-1:0] VENT_LAST = VENT_W'(VENT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_CONFIRM = 2'b01,
      S_ALARM   = 2'b10,
      S_VENT    = 2'b11
   } state_t;

   state_t            state_q, state_n;
   logic [CONF_W-1:0] conf_q, conf_n;
   logic [VENT_W-1:0] vent_q, vent_n;
   logic [2:0]        latched_q, latched_n;
   logic [CNT_W-1:0]  count_q, count_n;
   logic              alarm_q, alarm_n;
   logic              fan_q, fan_n;
   logic              valve_q, valve_n;
   logic              gas_present;
   logic              responding_n;

   assign gas_present = (gas_code != 3'b000);

   // State register and registered actuator outputs
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q   <= S_IDLE;
         conf_q    <= '0;
         vent_q    <= '0;
         latched_q <= '0;
         count_q   <= '0;
         alarm_q   <= 1'b0;
         fan_q     <= 1'b0;
         valve_q   <= 1'b0;
      end else begin
         state_q   <= state_n;
         conf_q    <= conf_n;
         vent_q    <= vent_n;
         latched_q <= latched_n;
         count_q   <= count_n;
         alarm_q   <= alarm_n;
         fan_q     <= fan_n;
         valve_q   <= valve_n;
      end
   end

   // Next-state, counters, gas accumulation and next actuator values
   always_comb begin
      state_n   = state_q;
      conf_n    = conf_q;
      vent_n    = vent_q;
      latched_n = latched_q;
      count_n   = count_q;

      case (state_q)
         S_IDLE: begin
            if (gas_present) begin
               state_n   = S_CONFIRM;
               conf_n    = CONF_W'(1);
               latched_n = gas_code;
            end
         end
         S_CONFIRM: begin
            if (!gas_present) begin
               state_n   = S_IDLE;
               latched_n = 3'b000;
               conf_n    = '0;
            end else begin
               latched_n = latched_q | gas_code;
               if (conf_q == CONF_LAST) begin
                  state_n = S_ALARM;
                  conf_n  = '0;
                  if (count_q != {CNT_W{1'b1}}) begin
                     count_n = count_q + CNT_W'(1);
                  end
               end else begin
                  conf_n = conf_q + CONF_W'(1);
               end
            end
         end
         S_ALARM: begin
            latched_n = latched_q | gas_code;
            if (ack && !gas_present) begin
               state_n = S_VENT;
               vent_n  = VENT_LAST;
            end
         end
         S_VENT: begin
            if (gas_present) begin
               // Same event re-entering alarm: counter untouched
               state_n   = S_ALARM;
               latched_n = latched_q | gas_code;
            end else if (vent_q == '0) begin
               state_n   = S_IDLE;
               latched_n = 3'b000;
            end else begin
               vent_n = vent_q - VENT_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      responding_n = (state_n == S_ALARM) || (state_n == S_VENT);
      alarm_n      = (state_n == S_ALARM);
      fan_n        = responding_n;
      valve_n      = responding_n && latched_n[0];
   end

   assign alarm       = alarm_q;
   assign fan_on      = fan_q;
   assign valve_close = valve_q;
   assign latched_gas = latched_q;
   assign state       = state_q;
   assign event_count = count_q;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Directed self-checking bench for gas_alarm_controller (CONFIRM=4, VENT=16, CNT_W=2).
module tb_gas_alarm_controller;

   logic       clk;
   logic       arst;
   logic [2:0] gas_code;
   logic       ack;
   logic       alarm;
   logic       fan_on;
   logic       valve_close;
   logic [2:0] latched_gas;
   logic [1:0] state;
   logic [1:0] event_count;
   logic [7:0] obs;

   int n_checks = 0;
   int n_fails  = 0;

   gas_alarm_controller #(
      .CONFIRM_CYCLES(4),
      .VENT_CYCLES   (16),
      .CNT_W         (2)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .gas_code   (gas_code),
      .ack        (ack),
      .alarm      (alarm),
      .fan_on     (fan_on),
      .valve_close(valve_close),
      .latched_gas(latched_gas),
      .state      (state),
      .event_count(event_count)
   );

   // Observed vector: {state, alarm, fan_on, valve_close, latched_gas}
   assign obs = {state, alarm, fan_on, valve_close, latched_gas};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic run_event(input logic [2:0] g);
      gas_code = g;
      ack      = 1'b0;
      repeat (4) step();
   endtask

   task automatic purge_to_idle();
      gas_code = 3'b000;
      ack      = 1'b1;
      step();
      ack = 1'b0;
      repeat (16) step();
   endtask

   task automatic test_reset();
      arst     = 1'b0;
      gas_code = 3'b001;
      ack      = 1'b1;
      repeat (3) step();
      n_checks++;
      if (obs !== 8'b00_000_000) begin
         $display("FAIL reset_outputs: got %b expected %b", obs, 8'b00_000_000);
         n_fails++;
      end
      n_checks++;
      if (event_count !== 2'd0) begin
         $display("FAIL reset_count: got %0d expected 0", event_count);
         n_fails++;
      end
      arst = 1'b1;
      step();
      n_checks++;
      if (obs !== 8'b01_000_001) begin
         $display("FAIL reset_release: got %b expected %b", obs, 8'b01_000_001);
         n_fails++;
      end
      gas_code = 3'b000;
      ack      = 1'b0;
      step();
      n_checks++;
      if (obs !== 8'b00_000_000) begin
         $display("FAIL reset_back_idle: got %b expected %b", obs, 8'b00_000_000);
         n_fails++;
      end
   endtask

   task automatic test_glitch();
      gas_code = 3'b010;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs !== 8'b01_000_010) begin
            $display("FAIL glitch_confirm[%0d]: got %b expected %b", i, obs, 8'b01_000_010);
            n_fails++;
         end
      end
      gas_code = 3'b000;
      step();
      n_checks++;
      if (obs !== 8'b00_000_000 || event_count !== 2'd0) begin
         $display("FAIL glitch_reject: got %b/%0d expected %b/0", obs, event_count, 8'b00_000_000);
         n_fails++;
      end
   endtask

   task automatic test_methane();
      gas_code = 3'b001;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs !== 8'b01_000_001) begin
            $display("FAIL methane_confirm[%0d]: got %b expected %b", i, obs, 8'b01_000_001);
            n_fails++;
         end
      end
      step();
      n_checks++;
      if (obs !== 8'b10_111_001 || event_count !== 2'd1) begin
         $display("FAIL methane_alarm: got %b/%0d expected %b/1", obs, event_count, 8'b10_111_001);
         n_fails++;
      end
      ack = 1'b1;
      repeat (2) step();
      n_checks++;
      if (obs !== 8'b10_111_001) begin
         $display("FAIL methane_ack_ignored: got %b expected %b", obs, 8'b10_111_001);
         n_fails++;
      end
      ack = 1'b0;
   endtask

   task automatic test_purge();
      gas_code = 3'b000;
      ack      = 1'b1;
      step();
      ack = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (obs !== 8'b11_011_001) begin
            $display("FAIL purge_vent[%0d]: got %b expected %b", i, obs, 8'b11_011_001);
            n_fails++;
         end
         step();
      end
      n_checks++;
      if (obs !== 8'b00_000_000 || event_count !== 2'd1) begin
         $display("FAIL purge_end: got %b/%0d expected %b/1", obs, event_count, 8'b00_000_000);
         n_fails++;
      end
   endtask

   task automatic test_mixed_reentry();
      run_event(3'b100);
      n_checks++;
      if (obs !== 8'b10_110_100 || event_count !== 2'd2) begin
         $display("FAIL mixed_alarm: got %b/%0d expected %b/2", obs, event_count, 8'b10_110_100);
         n_fails++;
      end
      gas_code = 3'b110;
      step();
      n_checks++;
      if (obs !== 8'b10_110_110) begin
         $display("FAIL mixed_accumulate: got %b expected %b", obs, 8'b10_110_110);
         n_fails++;
      end
      gas_code = 3'b000;
      ack      = 1'b1;
      step();
      ack = 1'b0;
      repeat (4) step();
      n_checks++;
      if (obs !== 8'b11_010_110) begin
         $display("FAIL mixed_vent5: got %b expected %b", obs, 8'b11_010_110);
         n_fails++;
      end
      gas_code = 3'b100;
      step();
      n_checks++;
      if (obs !== 8'b10_110_110 || event_count !== 2'd2) begin
         $display("FAIL mixed_reenter: got %b/%0d expected %b/2", obs, event_count, 8'b10_110_110);
         n_fails++;
      end
      // Full purge after a fresh ack; ack held high through VENT is ignored
      gas_code = 3'b000;
      ack      = 1'b1;
      step();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (obs !== 8'b11_010_110) begin
            $display("FAIL mixed_repurge[%0d]: got %b expected %b", i, obs, 8'b11_010_110);
            n_fails++;
         end
         step();
      end
      ack = 1'b0;
      n_checks++;
      if (obs !== 8'b00_000_000) begin
         $display("FAIL mixed_end: got %b expected %b", obs, 8'b00_000_000);
         n_fails++;
      end
   endtask

   task automatic test_back_to_back();
      gas_code = 3'b001;
      repeat (3) step();
      gas_code = 3'b000;
      step();
      n_checks++;
      if (obs !== 8'b00_000_000) begin
         $display("FAIL restart_idle: got %b expected %b", obs, 8'b00_000_000);
         n_fails++;
      end
      gas_code = 3'b010;
      step();
      gas_code = 3'b100;
      step();
      gas_code = 3'b001;
      step();
      n_checks++;
      if (obs !== 8'b01_000_111) begin
         $display("FAIL restart_count3: got %b expected %b", obs, 8'b01_000_111);
         n_fails++;
      end
      gas_code = 3'b010;
      step();
      n_checks++;
      if (obs !== 8'b10_111_111 || event_count !== 2'd3) begin
         $display("FAIL restart_alarm: got %b/%0d expected %b/3", obs, event_count, 8'b10_111_111);
         n_fails++;
      end
      purge_to_idle();
      n_checks++;
      if (obs !== 8'b00_000_000) begin
         $display("FAIL restart_end: got %b expected %b", obs, 8'b00_000_000);
         n_fails++;
      end
   endtask

   task automatic test_saturation_reset();
      run_event(3'b001);
      n_checks++;
      if (event_count !== 2'd3) begin
         $display("FAIL sat_event4: got %0d expected 3", event_count);
         n_fails++;
      end
      purge_to_idle();
      run_event(3'b001);
      n_checks++;
      if (obs !== 8'b10_111_001 || event_count !== 2'd3) begin
         $display("FAIL sat_event5: got %b/%0d expected %b/3", obs, event_count, 8'b10_111_001);
         n_fails++;
      end
      gas_code = 3'b000;
      ack      = 1'b1;
      step();
      ack = 1'b0;
      step();
      n_checks++;
      if (obs !== 8'b11_011_001) begin
         $display("FAIL sat_vent: got %b expected %b", obs, 8'b11_011_001);
         n_fails++;
      end
      #2 arst = 1'b0;
      #1;
      n_checks++;
      if (obs !== 8'b00_000_000 || event_count !== 2'd0) begin
         $display("FAIL async_reset: got %b/%0d expected %b/0", obs, event_count, 8'b00_000_000);
         n_fails++;
      end
      step();
      arst = 1'b1;
      step();
      n_checks++;
      if (obs !== 8'b00_000_000 || event_count !== 2'd0) begin
         $display("FAIL reset_resume: got %b/%0d expected %b/0", obs, event_count, 8'b00_000_000);
         n_fails++;
      end
   endtask

   initial begin
      arst     = 1'b0;
      gas_code = 3'b000;
      ack      = 1'b0;
      step();
      test_reset();
      test_glitch();
      test_methane();
      test_purge();
      test_mixed_reentry();
      test_back_to_back();
      test_saturation_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
